cal_sram_reader: RTL and testbench

- Read-side controller for the 512x38 calibration-process two-port SRAM. The calibration processor fills the SRAM through the write port (W_ADDR/W_EN).
- This block drives the SRAM read address (R_ADDR) and tracks the fixed RAM read latency.
- Read words go out as a valid/ready stream with backpressure, toward the packetiser/readout path.
- A bounded sweep is started by a START pulse; BUSY and a DONE pulse are reported.

---
 rtl/cal_rd_pkg.sv | 23 ++
 rtl/cal_rd_fifo.sv | 72 +++++++
 rtl/cal_sram_reader.sv | 160 ++++++++++++++++
 tb/tb_cal_sram_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_rd_pkg.sv
// Shared widths, limits and FSM state type for the calibration SRAM read path.
package cal_rd_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 38;
  localparam int MAX_WORDS = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Requested sweep lengths beyond the SRAM size are limited to one full pass.
  function automatic logic [ADDR_W:0] clamp_words(input logic [ADDR_W:0] n);
    if (n > (ADDR_W + 1)'(MAX_WORDS)) begin
      return (ADDR_W + 1)'(MAX_WORDS);
    end
    return n;
  endfunction

endpackage

// File: rtl/cal_rd_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
// Holds returned SRAM words (plus their last flag) until the stream accepts them.
module cal_rd_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop and advance pointers and count; a push into a full
  // FIFO is only taken when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/cal_sram_reader.sv
// Read-side controller for the calibration SRAM: sweeps a bounded address
// range, tracks the fixed RAM read latency and streams words out with
// valid/ready backpressure. Reads are only issued when the output FIFO is
// guaranteed to have room for them, so returning data is never dropped.
module cal_sram_reader
  import cal_rd_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [ADDR_W:0]   NUM_WORDS,
  output logic [ADDR_W-1:0] R_ADDR,
  input  logic [DATA_W-1:0] R_DATA,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam int              CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]  CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] last_q, last_d;

  logic [ADDR_W:0]   num_clamped;
  logic              issue;
  logic              last_issue;
  logic              credit_ok;
  logic [CNT_W-1:0]  inflight_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic              beat_fire;
  logic              head_last;

  assign num_clamped = clamp_words(NUM_WORDS);
  assign last_issue  = (remain_q == (ADDR_W + 1)'(1));
  assign beat_fire   = M_VALID && M_READY;
  assign head_last   = fifo_head[DATA_W];

  // Count reads still travelling through the RAM and grant a new read only
  // while FIFO occupancy plus outstanding reads leaves a free slot.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(vld_q[i]);
    end
    credit_ok = (({1'b0, fifo_count} + {1'b0, inflight_cnt}) < CREDIT_LIMIT);
  end

  // Sweep sequencer: latch the request, issue reads under credit, wait for
  // the final beat to leave, then pulse DONE for one cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    r_addr_d = r_addr_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (num_clamped == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d   = START_ADDR;
            remain_d = num_clamped;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue    = 1'b1;
          r_addr_d = addr_q;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - (ADDR_W + 1)'(1);
          if (last_issue) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (beat_fire && head_last && (inflight_cnt == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latency pipe: one valid bit per issued read plus a parallel last flag;
  // the top stage lines up with the matching word on R_DATA.
  always_comb begin
    vld_d     = vld_q;
    last_d    = last_q;
    vld_d[0]  = issue;
    last_d[0] = issue && last_issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  // Controller state, sweep bookkeeping, read address and latency pipe.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      r_addr_q <= '0;
      vld_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      r_addr_q <= r_addr_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
    end
  end

  cal_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETN),
    .push      (vld_q[RD_LAT-1]),
    .push_data ({last_q[RD_LAT-1], R_DATA}),
    .pop       (beat_fire),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign R_ADDR  = r_addr_q;
  assign M_VALID = !fifo_empty;
  assign M_DATA  = M_VALID ? fifo_head[DATA_W-1:0] : '0;
  assign M_LAST  = M_VALID && head_last;
  assign BUSY    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign DONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_cal_sram_reader.sv
// Directed self-checking bench for cal_sram_reader with a two-cycle SRAM model.
module tb_cal_sram_reader;
  import cal_rd_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   num_words;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] sram [512];
  logic [DATA_W-1:0] rdata_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [DATA_W-1:0] beat_data[$];
  logic              beat_last[$];
  int                beat_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  logic              busy_at_done = 1'b0;
  int                valid_seen = 0;
  int                stall_viol = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  cal_sram_reader #(
    .RD_LAT     (2),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK        (clk),
    .RESETN     (resetn),
    .START      (start),
    .START_ADDR (start_addr),
    .NUM_WORDS  (num_words),
    .R_ADDR     (r_addr),
    .R_DATA     (r_data),
    .M_DATA     (m_data),
    .M_VALID    (m_valid),
    .M_READY    (m_ready),
    .M_LAST     (m_last),
    .BUSY       (busy),
    .DONE       (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time beats and DONE relative to START.
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM read model: word for the address registered at edge N is sampled at edge N+2.
  always @(posedge clk) rdata_q <= sram[r_addr];
  assign r_data = rdata_q;

  // Stream monitor: record beats, DONE pulses and any change of a stalled beat.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_cyc.push_back(cyc);
      end
      if (m_valid) valid_seen++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  function automatic logic [63:0] exp_word(input int a);
    return 64'((a % 512) * 3);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    valid_seen = 0;
    stall_viol = 0;
  endtask

  task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] n);
    @(posedge clk);
    #1;
    start_addr = addr;
    num_words  = n;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string tag);
    int n = 0;
    while (done_cnt == base && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_output(tag, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic check_sweep(input string tag, input int addr, input int n);
    int bad = 0;
    int lasts = 0;
    check_output({tag, "_beats"}, 64'(beat_data.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i >= beat_data.size() || 64'(beat_data[i]) !== exp_word(addr + i)) bad++;
    end
    check_output({tag, "_data_mismatches"}, 64'(bad), 64'd0);
    foreach (beat_last[i]) if (beat_last[i]) lasts++;
    check_output({tag, "_last_count"}, 64'(lasts), 64'd1);
    if (beat_last.size() > 0) check_output({tag, "_last_on_final"}, beat_last[beat_last.size()-1], 1);
  endtask

  initial begin
    int base;
    int k;
    for (int a = 0; a < 512; a++) sram[a] = DATA_W'(a * 3);
    resetn     = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    num_words  = '0;
    m_ready    = 1'b1;

    // Reset state
    #12;
    check_output("rst_r_addr", r_addr, 0);
    check_output("rst_m_valid", m_valid, 0);
    check_output("rst_m_last", m_last, 0);
    check_output("rst_m_data", m_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("idle_busy", busy, 0);
    check_output("idle_valid", m_valid, 0);

    // Basic sweep: 5..8 -> 15,18,21,24
    $display("[TB] basic sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd5, 10'd4);
    check_output("basic_busy_after_start", busy, 1);
    wait_done(base, 50, "basic_done");
    check_sweep("basic", 5, 4);
    check_output("basic_first_beat_latency", 64'(beat_cyc[0] - start_cyc), 64'd4);
    check_output("basic_back_to_back", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
    check_output("basic_done_after_last", 64'(done_cyc - beat_cyc[3]), 64'd1);
    check_output("basic_busy_at_done", busy_at_done, 0);
    check_output("basic_last_mid", beat_last[2], 0);

    // Wrap-around: 510,511,0,1
    $display("[TB] wrap-around sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd510, 10'd4);
    wait_done(base, 50, "wrap_done");
    check_sweep("wrap", 510, 4);
    check_output("wrap_final_r_addr", r_addr, 1);

    // Zero-length request
    $display("[TB] zero-length sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd3, 10'd0);
    check_output("zero_done_now", done, 1);
    check_output("zero_busy", busy, 0);
    wait_done(base, 10, "zero_done");
    check_output("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check_output("zero_no_valid", 64'(valid_seen), 64'd0);

    // Backpressure: toggling ready, then a long stall
    $display("[TB] backpressure sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd40, 10'd16);
    for (int i = 0; i < 12; i++) begin
      m_ready = i[0];
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    k = beat_data.size();
    check_output("bp_stall_valid", m_valid, 1);
    check_output("bp_stall_head", m_data, exp_word(40 + k));
    check_output("bp_stall_r_addr", r_addr, exp_word(40 + k + FIFO_DEPTH - 1) / 3);
    m_ready = 1'b1;
    wait_done(base, 200, "bp_done");
    check_sweep("bp", 40, 16);
    check_output("bp_stall_stability", 64'(stall_viol), 64'd0);

    // Full range: 512 words wrapping through address 0
    $display("[TB] full-range sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd200, 10'd512);
    wait_done(base, 700, "full_done");
    check_sweep("full", 200, 512);

    // Oversized request limited to one full pass
    $display("[TB] clamped sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd7, 10'd700);
    wait_done(base, 700, "clamp_done");
    check_sweep("clamp", 7, 512);

    // START while busy is ignored
    $display("[TB] start while busy");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd60, 10'd16);
    repeat (3) @(posedge clk);
    apply_stimulus(9'd300, 10'd5);
    wait_done(base, 100, "busy_done");
    repeat (10) @(posedge clk);
    #1;
    check_sweep("busy", 60, 16);
    check_output("busy_single_done", 64'(done_cnt - base), 64'd1);

    // Reset in the middle of a sweep, then a clean restart
    $display("[TB] reset mid-sweep");
    clear_mon();
    base = done_cnt;
    apply_stimulus(9'd20, 10'd16);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("mid_beats_before_reset", 64'(beat_data.size()), 64'd3);
    check_output("mid_third_beat", beat_data[2], exp_word(22));
    resetn = 1'b0;
    #1;
    check_output("mid_rst_valid", m_valid, 0);
    check_output("mid_rst_data", m_data, 0);
    check_output("mid_rst_last", m_last, 0);
    check_output("mid_rst_r_addr", r_addr, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("mid_no_done", 64'(done_cnt - base), 64'd0);
    clear_mon();
    apply_stimulus(9'd100, 10'd4);
    wait_done(base, 50, "restart_done");
    check_sweep("restart", 100, 4);
    check_output("restart_first_beat_latency", 64'(beat_cyc[0] - start_cyc), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
